msgpass_buff_wr_arbiter: RTL and testbench

- Write-side scheduler for the dual-port message-passing buffer.
- Accepts write requests from two requesters (A: variable-node side, B: check-node side) over valid/ready handshakes, holds one request per requester, and drives the buffer's two write ports.
- Never drives both ports to the same address in the same cycle; same-address requests are serialised by a round-robin priority, so the buffer's write-conflict flag never asserts.
- Provides drain/flush sequencing, busy status and a conflict counter.

---
 rtl/msgPass_config_pkg.sv | 24 ++
 rtl/msgpass_wr_hold_slot.sv | 33 +++
 rtl/msgpass_buff_wr_arbiter.sv | 132 +++++++++++++
 tb/tb_msgpass_buff_wr_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/msgPass_config_pkg.sv
// Shared configuration for the message-passing buffer and its write-side arbiter.
package msgPass_config_pkg;

  localparam int MSGPASS_BUFF_ADDR_WIDTH  = 8;
  localparam int MSGPASS_BUFF_RDATA_WIDTH = 16;
  localparam int MSGPASS_WR_ARB_CNT_WIDTH = 16;

  typedef struct packed {
    logic [MSGPASS_BUFF_ADDR_WIDTH-1:0]  addr;
    logic [MSGPASS_BUFF_RDATA_WIDTH-1:0] data;
  } msgpass_wr_req_t;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } msgpass_wr_arb_state_e;

  typedef enum logic {
    PRIO_A = 1'b0,
    PRIO_B = 1'b1
  } msgpass_wr_prio_e;

endpackage

// File: rtl/msgpass_wr_hold_slot.sv
// One-entry write holding register: valid flag plus address/data payload.
module msgpass_wr_hold_slot #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  clear,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  valid,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] data
);

  // Load wins over clear so a slot can be refilled on the edge it issues.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     valid <= 1'b0;
    else if (load)  valid <= 1'b1;
    else if (clear) valid <= 1'b0;
  end

  // NOTE: payload is left unreset; it is only looked at while valid is set.
  always_ff @(posedge clk) begin
    if (load) begin
      addr <= load_addr;
      data <= load_data;
    end
  end

endmodule

// File: rtl/msgpass_buff_wr_arbiter.sv
// Write-side scheduler for the dual-port message buffer: holds one request per
// requester and serialises same-address writes by round-robin priority.
module msgpass_buff_wr_arbiter
  import msgPass_config_pkg::*;
#(
  parameter int ADDR_WIDTH = MSGPASS_BUFF_ADDR_WIDTH,
  parameter int DATA_WIDTH = MSGPASS_BUFF_RDATA_WIDTH,
  parameter int CNT_WIDTH  = MSGPASS_WR_ARB_CNT_WIDTH
) (
  input  logic                  write_clk_i,
  input  logic                  rstn,
  input  logic                  reqA_valid_i,
  output logic                  reqA_ready_o,
  input  logic [ADDR_WIDTH-1:0] reqA_addr_i,
  input  logic [DATA_WIDTH-1:0] reqA_data_i,
  input  logic                  reqB_valid_i,
  output logic                  reqB_ready_o,
  input  logic [ADDR_WIDTH-1:0] reqB_addr_i,
  input  logic [DATA_WIDTH-1:0] reqB_data_i,
  output logic [ADDR_WIDTH-1:0] buff_waddr_portA_o,
  output logic [DATA_WIDTH-1:0] buff_wdata_portA_o,
  output logic                  buff_wen_portA_o,
  output logic [ADDR_WIDTH-1:0] buff_waddr_portB_o,
  output logic [DATA_WIDTH-1:0] buff_wdata_portB_o,
  output logic                  buff_wen_portB_o,
  input  logic                  flush_req_i,
  output logic                  flush_done_o,
  output logic                  busy_o,
  output logic [CNT_WIDTH-1:0]  conflict_cnt_o,
  input  logic                  conflict_cnt_clr_i
);

  msgpass_wr_arb_state_e state;
  msgpass_wr_prio_e      prio;

  logic                  hold_a_v, hold_b_v;
  logic [ADDR_WIDTH-1:0] hold_a_addr, hold_b_addr;
  logic [DATA_WIDTH-1:0] hold_a_data, hold_b_data;
  logic                  coll, issue_a, issue_b, load_a, load_b, drained;

  assign coll    = hold_a_v && hold_b_v && (hold_a_addr == hold_b_addr);
  assign issue_a = hold_a_v && (!coll || prio == PRIO_A);
  assign issue_b = hold_b_v && (!coll || prio == PRIO_B);

  assign reqA_ready_o = (state == ST_RUN) && (!hold_a_v || issue_a);
  assign reqB_ready_o = (state == ST_RUN) && (!hold_b_v || issue_b);
  assign load_a       = reqA_valid_i && reqA_ready_o;
  assign load_b       = reqB_valid_i && reqB_ready_o;

  assign drained = !hold_a_v && !hold_b_v && buff_wen_portA_o && buff_wen_portB_o;
  assign busy_o  = hold_a_v | hold_b_v | !buff_wen_portA_o | !buff_wen_portB_o;

  msgpass_wr_hold_slot #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_slot_a (
    .clk       (write_clk_i),
    .rst_n     (rstn),
    .load      (load_a),
    .clear     (issue_a),
    .load_addr (reqA_addr_i),
    .load_data (reqA_data_i),
    .valid     (hold_a_v),
    .addr      (hold_a_addr),
    .data      (hold_a_data)
  );

  msgpass_wr_hold_slot #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_slot_b (
    .clk       (write_clk_i),
    .rst_n     (rstn),
    .load      (load_b),
    .clear     (issue_b),
    .load_addr (reqB_addr_i),
    .load_data (reqB_data_i),
    .valid     (hold_b_v),
    .addr      (hold_b_addr),
    .data      (hold_b_data)
  );

  // Write ports: active-low enable, address/data hold when nothing issues.
  always_ff @(posedge write_clk_i or negedge rstn) begin
    if (!rstn) begin
      buff_wen_portA_o   <= 1'b1;
      buff_wen_portB_o   <= 1'b1;
      buff_waddr_portA_o <= '0;
      buff_wdata_portA_o <= '0;
      buff_waddr_portB_o <= '0;
      buff_wdata_portB_o <= '0;
    end else begin
      buff_wen_portA_o <= !issue_a;
      buff_wen_portB_o <= !issue_b;
      if (issue_a) begin
        buff_waddr_portA_o <= hold_a_addr;
        buff_wdata_portA_o <= hold_a_data;
      end
      if (issue_b) begin
        buff_waddr_portB_o <= hold_b_addr;
        buff_wdata_portB_o <= hold_b_data;
      end
    end
  end

  // Priority passes to the loser of each collision; clear beats increment.
  always_ff @(posedge write_clk_i or negedge rstn) begin
    if (!rstn) begin
      prio           <= PRIO_A;
      conflict_cnt_o <= '0;
    end else begin
      if (coll) prio <= issue_a ? PRIO_B : PRIO_A;
      if (conflict_cnt_clr_i)
        conflict_cnt_o <= '0;
      else if (coll && (conflict_cnt_o != {CNT_WIDTH{1'b1}}))
        conflict_cnt_o <= conflict_cnt_o + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge write_clk_i or negedge rstn) begin
    if (!rstn) begin
      state        <= ST_RUN;
      flush_done_o <= 1'b0;
    end else begin
      flush_done_o <= 1'b0;
      unique case (state)
        ST_RUN:   if (flush_req_i) state <= ST_DRAIN;
        ST_DRAIN: if (drained) begin
          state        <= ST_DONE;
          flush_done_o <= 1'b1;
        end
        ST_DONE:  state <= ST_RUN;
        default:  state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_msgpass_buff_wr_arbiter.sv
// Directed bench for msgpass_buff_wr_arbiter: vector table plus corner-case
// sequences, with a small dual-port buffer model watching the write ports.
module tb_msgpass_buff_wr_arbiter;
  import msgPass_config_pkg::*;

  localparam int AW = MSGPASS_BUFF_ADDR_WIDTH;
  localparam int DW = MSGPASS_BUFF_RDATA_WIDTH;
  localparam int NV = 29;

  typedef struct packed {
    logic          rdy_a, rdy_b, wen_a, wen_b, busy, done;
    logic [AW-1:0] addr_a, addr_b;
    logic [DW-1:0] data_a, data_b;
    logic [15:0]   cnt;
  } obs_t;

  typedef struct {
    logic            av, bv, fl, clr;
    msgpass_wr_req_t a, b;
    logic            ra, rb, wa, wb, busy, done;
    msgpass_wr_req_t ea, eb;
    int              cnt;
  } vec_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic av = 1'b0, bv = 1'b0, fl = 1'b0, clr = 1'b0;
  logic [AW-1:0] aa = '0, ba = '0;
  logic [DW-1:0] ad = '0, bd = '0;

  logic          rdy_a0, rdy_b0, wen_a0, wen_b0, busy0, done0;
  logic [AW-1:0] waddr_a0, waddr_b0;
  logic [DW-1:0] wdata_a0, wdata_b0;
  logic [15:0]   cnt0;
  logic          rdy_a1, rdy_b1, wen_a1, wen_b1, busy1, done1;
  logic [AW-1:0] waddr_a1, waddr_b1;
  logic [DW-1:0] wdata_a1, wdata_b1;
  logic [1:0]    cnt1;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  int            conflict_hits = 0;
  int            passed = 0, total = 0;
  vec_t          vecs [NV];

  always #5 clk = ~clk;

  msgpass_buff_wr_arbiter dut (
    .write_clk_i(clk), .rstn(rstn),
    .reqA_valid_i(av), .reqA_ready_o(rdy_a0), .reqA_addr_i(aa), .reqA_data_i(ad),
    .reqB_valid_i(bv), .reqB_ready_o(rdy_b0), .reqB_addr_i(ba), .reqB_data_i(bd),
    .buff_waddr_portA_o(waddr_a0), .buff_wdata_portA_o(wdata_a0), .buff_wen_portA_o(wen_a0),
    .buff_waddr_portB_o(waddr_b0), .buff_wdata_portB_o(wdata_b0), .buff_wen_portB_o(wen_b0),
    .flush_req_i(fl), .flush_done_o(done0), .busy_o(busy0),
    .conflict_cnt_o(cnt0), .conflict_cnt_clr_i(clr)
  );

  msgpass_buff_wr_arbiter #(.CNT_WIDTH(2)) dut_sat (
    .write_clk_i(clk), .rstn(rstn),
    .reqA_valid_i(av), .reqA_ready_o(rdy_a1), .reqA_addr_i(aa), .reqA_data_i(ad),
    .reqB_valid_i(bv), .reqB_ready_o(rdy_b1), .reqB_addr_i(ba), .reqB_data_i(bd),
    .buff_waddr_portA_o(waddr_a1), .buff_wdata_portA_o(wdata_a1), .buff_wen_portA_o(wen_a1),
    .buff_waddr_portB_o(waddr_b1), .buff_wdata_portB_o(wdata_b1), .buff_wen_portB_o(wen_b1),
    .flush_req_i(fl), .flush_done_o(done1), .busy_o(busy1),
    .conflict_cnt_o(cnt1), .conflict_cnt_clr_i(clr)
  );

  // Buffer model: the enable is registered, so it holds for the whole cycle.
  always @(negedge clk) begin
    if (rstn) begin
      if (!wen_a0) mem[waddr_a0] <= wdata_a0;
      if (!wen_b0) mem[waddr_b0] <= wdata_b0;
      if (!wen_a0 && !wen_b0 && waddr_a0 == waddr_b0) conflict_hits <= conflict_hits + 1;
    end
  end

  function automatic obs_t get_obs(input int d);
    obs_t o;
    if (d == 0) o = '{rdy_a0, rdy_b0, wen_a0, wen_b0, busy0, done0,
                      waddr_a0, waddr_b0, wdata_a0, wdata_b0, cnt0};
    else        o = '{rdy_a1, rdy_b1, wen_a1, wen_b1, busy1, done1,
                      waddr_a1, waddr_b1, wdata_a1, wdata_b1, {14'd0, cnt1}};
    return o;
  endfunction

  function automatic vec_t mk(input int i_av, i_aa, i_ad, i_bv, i_ba, i_bd, i_fl, i_clr,
                              input int e_ra, e_rb, e_wa, e_wb, e_aa, e_ad, e_ba, e_bd,
                              input int e_busy, e_done, e_cnt);
    vec_t v;
    v.av = i_av[0]; v.a = '{addr: AW'(i_aa), data: DW'(i_ad)};
    v.bv = i_bv[0]; v.b = '{addr: AW'(i_ba), data: DW'(i_bd)};
    v.fl = i_fl[0]; v.clr = i_clr[0];
    v.ra = e_ra[0]; v.rb = e_rb[0]; v.wa = e_wa[0]; v.wb = e_wb[0];
    v.ea = '{addr: AW'(e_aa), data: DW'(e_ad)};
    v.eb = '{addr: AW'(e_ba), data: DW'(e_bd)};
    v.busy = e_busy[0]; v.done = e_done[0]; v.cnt = e_cnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic i_av, input int i_aa, i_ad, input logic i_bv,
                       input int i_ba, i_bd, input logic i_fl, i_clr);
    av = i_av; aa = AW'(i_aa); ad = DW'(i_ad);
    bv = i_bv; ba = AW'(i_ba); bd = DW'(i_bd);
    fl = i_fl; clr = i_clr;
  endtask

  task automatic apply_vec(input int i);
    obs_t  o;
    string p;
    int    ec;
    drive(vecs[i].av, int'(vecs[i].a.addr), int'(vecs[i].a.data),
          vecs[i].bv, int'(vecs[i].b.addr), int'(vecs[i].b.data), vecs[i].fl, vecs[i].clr);
    #3;
    for (int d = 0; d < 2; d++) begin
      o  = get_obs(d);
      p  = $sformatf("v%0d/dut%0d", i, d);
      ec = (d == 1 && vecs[i].cnt > 3) ? 3 : vecs[i].cnt;
      check({p, " ready_a"}, o.rdy_a, vecs[i].ra);
      check({p, " ready_b"}, o.rdy_b, vecs[i].rb);
      check({p, " wen_a"},   o.wen_a, vecs[i].wa);
      check({p, " wen_b"},   o.wen_b, vecs[i].wb);
      check({p, " busy"},    o.busy,  vecs[i].busy);
      check({p, " done"},    o.done,  vecs[i].done);
      check({p, " cnt"},     o.cnt,   ec);
      if (!vecs[i].wa) begin
        check({p, " addr_a"}, o.addr_a, vecs[i].ea.addr);
        check({p, " data_a"}, o.data_a, vecs[i].ea.data);
      end
      if (!vecs[i].wb) begin
        check({p, " addr_b"}, o.addr_b, vecs[i].eb.addr);
        check({p, " data_b"}, o.data_b, vecs[i].eb.data);
      end
    end
    next_cycle();
  endtask

  initial begin
    //               av aa  ad    bv ba bd    fl clr  ra rb wa wb  eaa ead   eba ebd   busy done cnt
    vecs[0]  = mk(1, 3, 'h11, 1, 5, 'h22, 0, 0,   1, 1, 1, 1,  0, 0,     0, 0,     0, 0, 0);
    vecs[1]  = mk(0, 0, 0,    0, 0, 0,    0, 0,   1, 1, 1, 1,  0, 0,     0, 0,     1, 0, 0);
    vecs[2]  = mk(0, 0, 0,    0, 0, 0,    0, 0,   1, 1, 0, 0,  3, 'h11,  5, 'h22,  1, 0, 0);
    vecs[3]  = mk(0, 0, 0,    0, 0, 0,    0, 0,   1, 1, 1, 1,  0, 0,     0, 0,     0, 0, 0);
    vecs[4]  = mk(1, 7, 'hAA, 1, 7, 'hBB, 0, 0,   1, 1, 1, 1,  0, 0,     0, 0,     0, 0, 0);
    vecs[5]  = mk(0, 0, 0,    0, 0, 0,    0, 0,   1, 0, 1, 1,  0, 0,     0, 0,     1, 0, 0);
    vecs[6]  = mk(0, 0, 0,    0, 0, 0,    0, 0,   1, 1, 0, 1,  7, 'hAA,  0, 0,     1, 0, 1);
    vecs[7]  = mk(0, 0, 0,    0, 0, 0,    0, 0,   1, 1, 1, 0,  0, 0,     7, 'hBB,  1, 0, 1);
    vecs[8]  = mk(0, 0, 0,    0, 0, 0,    0, 0,   1, 1, 1, 1,  0, 0,     0, 0,     0, 0, 1);
    // reset in between: priority back to A, counter back to 0
    vecs[9]  = mk(1, 9, 'h01, 1, 9, 'h02, 0, 0,   1, 1, 1, 1,  0, 0,     0, 0,     0, 0, 0);
    vecs[10] = mk(1, 9, 'h03, 0, 0, 0,    0, 0,   1, 0, 1, 1,  0, 0,     0, 0,     1, 0, 0);
    vecs[11] = mk(0, 0, 0,    0, 0, 0,    0, 0,   0, 1, 0, 1,  9, 'h01,  0, 0,     1, 0, 1);
    vecs[12] = mk(0, 0, 0,    0, 0, 0,    0, 0,   1, 1, 1, 0,  0, 0,     9, 'h02,  1, 0, 2);
    vecs[13] = mk(0, 0, 0,    0, 0, 0,    0, 0,   1, 1, 0, 1,  9, 'h03,  0, 0,     1, 0, 2);
    vecs[14] = mk(0, 0, 0,    0, 0, 0,    0, 0,   1, 1, 1, 1,  0, 0,     0, 0,     0, 0, 2);
    vecs[15] = mk(1, 1, 'h31, 1, 2, 'h32, 0, 0,   1, 1, 1, 1,  0, 0,     0, 0,     0, 0, 2);
    vecs[16] = mk(0, 0, 0,    0, 0, 0,    1, 0,   1, 1, 1, 1,  0, 0,     0, 0,     1, 0, 2);
    vecs[17] = mk(1, 5, 'h55, 0, 0, 0,    1, 0,   0, 0, 0, 0,  1, 'h31,  2, 'h32,  1, 0, 2);
    vecs[18] = mk(1, 5, 'h55, 0, 0, 0,    0, 0,   0, 0, 1, 1,  0, 0,     0, 0,     0, 0, 2);
    vecs[19] = mk(1, 5, 'h55, 0, 0, 0,    0, 0,   0, 0, 1, 1,  0, 0,     0, 0,     0, 1, 2);
    vecs[20] = mk(1, 5, 'h55, 0, 0, 0,    0, 0,   1, 1, 1, 1,  0, 0,     0, 0,     0, 0, 2);
    vecs[21] = mk(0, 0, 0,    0, 0, 0,    0, 0,   1, 1, 1, 1,  0, 0,     0, 0,     1, 0, 2);
    vecs[22] = mk(0, 0, 0,    0, 0, 0,    0, 0,   1, 1, 0, 1,  5, 'h55,  0, 0,     1, 0, 2);
    vecs[23] = mk(0, 0, 0,    0, 0, 0,    0, 0,   1, 1, 1, 1,  0, 0,     0, 0,     0, 0, 2);
    vecs[24] = mk(0, 0, 0,    0, 0, 0,    1, 0,   1, 1, 1, 1,  0, 0,     0, 0,     0, 0, 2);
    vecs[25] = mk(0, 0, 0,    0, 0, 0,    0, 0,   0, 0, 1, 1,  0, 0,     0, 0,     0, 0, 2);
    vecs[26] = mk(0, 0, 0,    0, 0, 0,    0, 0,   0, 0, 1, 1,  0, 0,     0, 0,     0, 1, 2);
    vecs[27] = mk(0, 0, 0,    0, 0, 0,    0, 1,   1, 1, 1, 1,  0, 0,     0, 0,     0, 0, 2);
    vecs[28] = mk(0, 0, 0,    0, 0, 0,    0, 0,   1, 1, 1, 1,  0, 0,     0, 0,     0, 0, 0);

    // Reset state, observed while rstn is still low.
    #12;
    check("rst wen_a", wen_a0, 1'b1);
    check("rst wen_b", wen_b0, 1'b1);
    check("rst addr_a", waddr_a0, 0);
    check("rst data_b", wdata_b0, 0);
    check("rst busy", busy0, 1'b0);
    check("rst done", done0, 1'b0);
    check("rst cnt", cnt0, 0);
    rstn = 1'b1;
    next_cycle();

    for (int i = 0; i <= 8; i++) apply_vec(i);
    rstn = 1'b0;
    next_cycle();
    rstn = 1'b1;
    for (int i = 9; i < NV; i++) apply_vec(i);

    // Saturation: five collision edges on address 4.
    drive(1, 4, 'h61, 1, 4, 'h62, 0, 0);
    repeat (5) next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) next_cycle();
    #3;
    check("sat cnt16", cnt0, 5);
    check("sat cnt2", cnt1, 3);
    check("sat busy", busy0, 1'b0);
    next_cycle();

    // Clear on the same edge as a collision.
    drive(1, 6, 'h71, 1, 6, 'h72, 0, 0);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    #3;
    check("clr pre cnt16", cnt0, 5);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #3;
    check("clr cnt16", cnt0, 0);
    check("clr cnt2", cnt1, 0);
    repeat (2) next_cycle();
    #3;
    check("clr hold cnt16", cnt0, 0);
    next_cycle();

    // Asynchronous reset with both slots valid and port A writing; leaves prio=B.
    drive(1, 3, 'h41, 1, 3, 'h42, 0, 0);
    next_cycle();
    drive(1, 10, 'h43, 0, 0, 0, 0, 0);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    check("arst pre wen_a", wen_a0, 1'b0);
    check("arst pre busy", busy0, 1'b1);
    rstn = 1'b0;
    #1;
    check("arst wen_a", wen_a0, 1'b1);
    check("arst wen_b", wen_b0, 1'b1);
    check("arst busy", busy0, 1'b0);
    check("arst addr_a", waddr_a0, 0);
    check("arst sat wen_a", wen_a1, 1'b1);
    next_cycle();
    rstn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      #3;
      check($sformatf("post rst %0d wen_a", k), wen_a0, 1'b1);
      check($sformatf("post rst %0d wen_b", k), wen_b0, 1'b1);
      check($sformatf("post rst %0d busy", k), busy0, 1'b0);
    end
    next_cycle();

    // Priority back to A after reset.
    drive(1, 12, 'h81, 1, 12, 'h82, 0, 0);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    next_cycle();
    #3;
    check("prio wen_a", wen_a0, 1'b0);
    check("prio wen_b", wen_b0, 1'b1);
    check("prio data_a", wdata_a0, 'h81);
    next_cycle();
    #3;
    check("prio2 wen_b", wen_b0, 1'b0);
    check("prio2 data_b", wdata_b0, 'h82);
    repeat (2) next_cycle();

    check("mem[7]", mem[7], 'hBB);
    check("mem[9]", mem[9], 'h03);
    check("mem[1]", mem[1], 'h31);
    check("mem[2]", mem[2], 'h32);
    check("mem[5]", mem[5], 'h55);
    check("mem[12]", mem[12], 'h82);
    check("buffer conflicts", conflict_hits, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
